spi_rx_deser: RTL and testbench
===============================

SPI_RX_DESER -- requirements
Module: spi_rx_deser

Interface
REQ-001 Parameter WIDTH, default 16, word length in bits; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 0; 0 = MSB-first shift, 1 = LSB-first shift.
REQ-003 Parameter DEPTH, default 2, receive buffer entries; power of two, legal range 1..8.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sampling  input  1  one-clk strobe from the rate generator marking a valid sdin bit.
REQ-007 en  input  1  frame enable (chip-select equivalent); high = frame active.
REQ-008 sdin  input  1  serial data in.
REQ-009 dout  output  WIDTH  head word of the receive buffer.
REQ-010 dout_valid  output  1  buffer not empty; dout is meaningful.
REQ-011 dout_ready  input  1  consumer accept; a pop occurs when dout_valid && dout_ready.
REQ-012 level  output  $clog2(DEPTH)+1  number of words held.
REQ-013 bit_cnt  output  $clog2(WIDTH)  bits received in the current word.
REQ-014 overrun  output  1  sticky flag: a completed word was dropped.
REQ-015 ovr_clr  input  1  one-clk pulse that clears overrun.

Function
REQ-016 A shift occurs only on a clk edge with sampling && en both high.
REQ-017 MSB-first shift: sreg <= {sreg[WIDTH-2:0], sdin}. LSB-first shift: sreg <= {sdin, sreg[WIDTH-1:1]}.
REQ-018 bit_cnt increments on each shift; on the shift where bit_cnt == WIDTH-1 it wraps to 0 and the word completes.
REQ-019 On completion, the post-shift word is written to the buffer tail; dout_valid is visible on the next clk (1-cycle latency, no bypass).
REQ-020 While en is low, bit_cnt and sreg are held at 0.
REQ-021 A partially received word is discarded when en falls; nothing is written to the buffer.
REQ-022 Buffer behaviour:
  - FIFO ordering.
  - dout always equals the oldest entry.
  - dout is 0 when empty.
REQ-023 Completion while full with no pop in the same cycle: the word is dropped, the buffer is unchanged, and overrun is set on the next clk.
REQ-024 Completion while full with a pop in the same cycle: the push is accepted, level stays DEPTH, and overrun is not set.
REQ-025 A pop with dout_valid low has no effect.
REQ-026 ovr_clr clears overrun; if ovr_clr and a new overrun occur in the same cycle, overrun remains 1.
REQ-027 sampling while en is low is ignored.
REQ-028 dout_ready has no effect on shifting.

Reset
REQ-029 While rst is high: sreg = 0, bit_cnt = 0, buffer empty (level = 0, dout_valid = 0, dout = 0), overrun = 0.
REQ-030 rst asserted mid-frame or mid-pop aborts the operation; no word is delivered after rst deasserts.
REQ-031 The first shift after reset occurs no earlier than the first clk edge after rst falls.

Structure
REQ-032 The shared package spi_pkg holds:
  - the default values of WIDTH and DEPTH;
  - the legal-range limit constants.
REQ-033 The receive buffer is one sub-module, spi_sync_fifo, parametrised by WIDTH and DEPTH, with ports push, pop, din, dout, empty, full and level.
REQ-034 The shift/count logic remains in spi_rx_deser.

Verification
REQ-035 The bench shall cover the following directed scenarios (WIDTH=16, DEPTH=2 unless stated):
  - MSB-first frame: shift 0xA5C3 with dout_ready=1 -> dout=16'hA5C3 and dout_valid=1 exactly 1 clk after the 16th sampling, then dout_valid=0.
  - LSB_FIRST=1: shift bit sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 -> dout=16'hA5C3.
  - en dropped after 7 bits, then full word 0x1234 -> single word 0x1234 delivered; bit_cnt=0 while en low.
  - dout_ready=0, three words 0x0001, 0x0002, 0x0003 -> level=2, overrun=1, dout=0x0001; ovr_clr -> overrun=0; two pops yield 0x0001, 0x0002.
  - Full buffer, pop coincident with completion of 0x00FF -> level stays 2, overrun=0, pop order 0x0002, 0x00FF.
  - rst pulsed after 10 bits with one word buffered -> dout_valid=0, level=0, bit_cnt=0; next full word 0xBEEF is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI receive path.
//   Default word length and buffer depth, plus the legal parameter limits
//   that spi_rx_deser checks at elaboration time.
package spi_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned DEPTH_DEFAULT = 2;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;
    localparam int unsigned DEPTH_MIN = 1;
    localparam int unsigned DEPTH_MAX = 8;

    // True when v is a non-zero power of two.
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: single-clock FIFO holding received SPI words.
//   clk, rst     : system clock, asynchronous active-high reset
//   push, din    : write din at the tail (accepted when not full, or when
//                  a pop happens in the same cycle)
//   pop          : remove the head entry (ignored when empty)
//   dout         : head entry, forced to 0 while empty
//   empty, full  : occupancy flags
//   level        : number of entries held (0..DEPTH)
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    // A one-entry buffer still needs a 1-bit pointer.
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        empty   = (count == '0);
        full    = (count == LW'(DEPTH));
        do_pop  = pop && !empty;
        // A simultaneous pop frees the slot the push needs when full.
        do_push = push && (!full || do_pop);
        dout    = empty ? '0 : mem[rd_ptr];
        level   = count;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_rx_deser.sv
// spi_rx_deser: SPI receive deserialiser with a small word buffer.
//   clk, rst    : system clock, asynchronous active-high reset
//   sampling    : one-clk strobe marking a valid sdin bit
//   en          : frame enable; low discards any partial word
//   sdin        : serial data in
//   dout        : oldest buffered word (0 when empty)
//   dout_valid  : buffer not empty
//   dout_ready  : consumer accept; pops when dout_valid is high
//   level       : number of buffered words
//   bit_cnt     : bits received in the current word
//   overrun     : sticky, set when a completed word had no room
//   ovr_clr     : one-clk pulse clearing overrun (a new overrun wins)
module spi_rx_deser
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEFAULT,
    parameter bit          LSB_FIRST = 1'b0,
    parameter int unsigned DEPTH     = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sampling,
    input  logic                       en,
    input  logic                       sdin,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt,
    output logic                       overrun,
    input  logic                       ovr_clr
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("spi_rx_deser: WIDTH out of range");
    end
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("spi_rx_deser: DEPTH must be a power of two within range");
    end

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic             shift;
    logic             word_done;
    logic             fifo_empty;
    logic             fifo_full;
    logic             drop;

    always_comb begin
        shift     = sampling && en;
        sreg_next = LSB_FIRST ? {sdin, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], sdin};
        word_done = shift && (bit_cnt == LAST_BIT);
        // Dropped only when full and no pop frees a slot this cycle.
        drop      = word_done && fifo_full && !(dout_ready && !fifo_empty);
        dout_valid = !fifo_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (!en) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (sampling) begin
            sreg    <= sreg_next;
            bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    // The buffer receives the post-shift word, so the completing bit is
    // included without waiting a cycle for sreg to update.
    spi_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (word_done),
        .pop   (dout_ready),
        .din   (sreg_next),
        .dout  (dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

endmodule

// File: tb/tb_spi_rx_deser.sv
module tb_spi_rx_deser;

    localparam int unsigned W = 16;
    localparam int unsigned D = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sampling = 1'b0;
    logic en = 1'b0;
    logic sdin = 1'b0;
    logic dout_ready = 1'b0;
    logic ovr_clr = 1'b0;

    logic [W-1:0] dout_w [2];
    logic         valid_w [2];
    logic [1:0]   level_w [2];
    logic [3:0]   bcnt_w [2];
    logic         ovr_w [2];

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    spi_rx_deser #(.WIDTH(W), .LSB_FIRST(1'b0), .DEPTH(D)) u_msb (
        .clk(clk), .rst(rst), .sampling(sampling), .en(en), .sdin(sdin),
        .dout(dout_w[0]), .dout_valid(valid_w[0]), .dout_ready(dout_ready),
        .level(level_w[0]), .bit_cnt(bcnt_w[0]), .overrun(ovr_w[0]), .ovr_clr(ovr_clr)
    );

    spi_rx_deser #(.WIDTH(W), .LSB_FIRST(1'b1), .DEPTH(D)) u_lsb (
        .clk(clk), .rst(rst), .sampling(sampling), .en(en), .sdin(sdin),
        .dout(dout_w[1]), .dout_valid(valid_w[1]), .dout_ready(dout_ready),
        .level(level_w[1]), .bit_cnt(bcnt_w[1]), .overrun(ovr_w[1]), .ovr_clr(ovr_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per instance a bit count, a word being assembled
    // arithmetically, a queue of delivered words and the sticky flag.
    int unsigned m_cnt [2];
    int unsigned m_acc [2];
    int unsigned mq [2][$];
    bit          m_ovr [2];
    bit          popped;
    bit          was_full;
    bit          dropped;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0;
                m_acc[i] = 0;
                mq[i].delete();
                m_ovr[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                popped   = dout_ready && (mq[i].size() > 0);
                was_full = (mq[i].size() == D);
                dropped  = 1'b0;
                if (popped) void'(mq[i].pop_front());
                if (!en) begin
                    m_cnt[i] = 0;
                    m_acc[i] = 0;
                end else if (sampling) begin
                    if (i == 0) m_acc[i] = ((m_acc[i] * 2) + 32'(sdin)) % (1 << W);
                    else        m_acc[i] = m_acc[i] + (32'(sdin) << m_cnt[i]);
                    m_cnt[i]++;
                    if (m_cnt[i] == W) begin
                        if (!was_full || popped) mq[i].push_back(m_acc[i]);
                        else dropped = 1'b1;
                        m_cnt[i] = 0;
                        m_acc[i] = 0;
                    end
                end
                if (dropped) m_ovr[i] = 1'b1;
                else if (ovr_clr) m_ovr[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("model_dout%0d", i), 32'(dout_w[i]),
                      (mq[i].size() > 0) ? mq[i][0] : 32'd0);
                check($sformatf("model_valid%0d", i), 32'(valid_w[i]), 32'(mq[i].size() > 0));
                check($sformatf("model_level%0d", i), 32'(level_w[i]), mq[i].size());
                check($sformatf("model_bitcnt%0d", i), 32'(bcnt_w[i]), m_cnt[i]);
                check($sformatf("model_ovr%0d", i), 32'(ovr_w[i]), 32'(m_ovr[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sdin is toggled while sampling is low so an ignored strobe-less bit
    // would corrupt the word if the gating were wrong.
    task automatic shift_bit(input logic b);
        sampling = 1'b1;
        sdin     = b;
        tick();
        sampling = 1'b0;
        sdin     = ~b;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 15; i > 15 - n; i--) begin
            tick();
            shift_bit(w[i]);
        end
    endtask

    task automatic send_word(input logic [15:0] w, input logic ready_last);
        send_bits(w, 15);
        tick();
        if (ready_last) dout_ready = 1'b1;
        shift_bit(w[0]);
    endtask

    initial begin
        tick();
        tick();
        chk_on = 1'b1;
        check("rst_dout", 32'(dout_w[0]), 32'h0);
        check("rst_valid", 32'(valid_w[0]), 32'h0);
        check("rst_level", 32'(level_w[0]), 32'h0);
        check("rst_ovr", 32'(ovr_w[0]), 32'h0);
        rst = 1'b0;

        // MSB-first frame
        en = 1'b1;
        dout_ready = 1'b1;
        send_word(16'hA5C3, 1'b1);
        check("msb_dout", 32'(dout_w[0]), 32'hA5C3);
        check("msb_valid", 32'(valid_w[0]), 32'h1);
        check("msb_lsbinst_dout", 32'(dout_w[1]), 32'hC3A5);
        tick();
        check("msb_valid_after", 32'(valid_w[0]), 32'h0);

        // LSB-first bit order 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
        send_word(16'hC3A5, 1'b1);
        check("lsb_dout", 32'(dout_w[1]), 32'hA5C3);
        check("lsb_valid", 32'(valid_w[1]), 32'h1);
        tick();
        check("lsb_valid_after", 32'(valid_w[1]), 32'h0);

        // Partial word discarded when en drops
        send_bits(16'h5555, 7);
        check("part_bitcnt", 32'(bcnt_w[0]), 32'd7);
        en = 1'b0;
        tick();
        check("enlow_bitcnt", 32'(bcnt_w[0]), 32'd0);
        shift_bit(1'b1);
        check("enlow_sampling_bitcnt", 32'(bcnt_w[1]), 32'd0);
        check("enlow_level", 32'(level_w[0]), 32'd0);
        en = 1'b1;
        send_word(16'h1234, 1'b1);
        check("after_en_dout", 32'(dout_w[0]), 32'h1234);
        check("after_en_level", 32'(level_w[0]), 32'd1);
        tick();
        check("after_en_empty", 32'(valid_w[0]), 32'h0);

        // Overrun with consumer stalled
        dout_ready = 1'b0;
        send_word(16'h0001, 1'b0);
        send_word(16'h0002, 1'b0);
        send_word(16'h0003, 1'b0);
        check("ovr_level", 32'(level_w[0]), 32'd2);
        check("ovr_flag", 32'(ovr_w[0]), 32'h1);
        check("ovr_dout", 32'(dout_w[0]), 32'h0001);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_cleared", 32'(ovr_w[0]), 32'h0);

        // Pop coincident with completion while full
        send_word(16'h00FF, 1'b1);
        check("coinc_level", 32'(level_w[0]), 32'd2);
        check("coinc_ovr", 32'(ovr_w[0]), 32'h0);
        check("coinc_dout0", 32'(dout_w[0]), 32'h0002);
        tick();
        check("coinc_dout1", 32'(dout_w[0]), 32'h00FF);
        tick();
        check("coinc_drained", 32'(valid_w[0]), 32'h0);

        // Reset mid-frame with a word buffered
        dout_ready = 1'b0;
        send_word(16'h1111, 1'b0);
        send_bits(16'h0F0F, 10);
        check("pre_rst_bitcnt", 32'(bcnt_w[0]), 32'd10);
        check("pre_rst_level", 32'(level_w[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(valid_w[0]), 32'h0);
        check("rst_mid_level", 32'(level_w[0]), 32'd0);
        check("rst_mid_bitcnt", 32'(bcnt_w[0]), 32'd0);
        check("rst_mid_dout", 32'(dout_w[0]), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        dout_ready = 1'b1;
        send_word(16'hBEEF, 1'b1);
        check("post_rst_dout", 32'(dout_w[0]), 32'hBEEF);
        check("post_rst_level", 32'(level_w[0]), 32'd1);
        tick();
        check("post_rst_drained", 32'(valid_w[0]), 32'h0);
        tick();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
